hls_deadlock_monitor_gen: RTL and testbench

Parametrised deadlock monitor for an HLS dataflow region: it watches the idle and channel-block status of N_PROC processes and N_AXIS AXI-Stream ports. It flags a deadlock once every process has been stopped for PERSIST consecutive cycles while at least one AXIS-owning process is AXIS-blocked. It sits beside the dataflow instance in the capture path (e.g. adc_capture) and feeds the debug/status register bank. Compared with the fixed-width per-instance monitors, it adds configurable process and stream counts, a persistence filter, sticky status with clear, first-blocked-stream capture and an event counter.

---
 rtl/hls_deadlock_monitor_gen.sv | 137 +++++++++++++
 tb/tb_hls_deadlock_monitor_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hls_deadlock_monitor_gen.sv
// Deadlock monitor for an HLS dataflow region: flags when every process is stopped
// and an AXIS-owning process is stream-blocked, with persistence filter and sticky status.
module hls_deadlock_monitor_gen #(
  parameter int N_PROC = 3,
  parameter int N_AXIS = 2,
  parameter logic [N_PROC*N_AXIS-1:0] PROC_AXIS_MASK = (N_PROC*N_AXIS)'(3) << N_AXIS,
  parameter int PERSIST = 1,
  parameter int CNT_W = 16,
  parameter int IDX_W = (N_AXIS > 1) ? $clog2(N_AXIS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_PROC-1:0] inst_idle_sigs,
  input  logic [N_PROC-1:0] inst_block_sigs,
  input  logic [N_PROC-1:0] child_block,
  input  logic              clear,
  output logic              block,
  output logic              block_sticky,
  output logic [N_AXIS-1:0] axis_block_info,
  output logic [IDX_W-1:0]  first_axis_idx,
  output logic [CNT_W-1:0]  event_count
);
  localparam int PCNT_W = $clog2(PERSIST + 1);

  typedef enum logic [1:0] {IDLE, ARMED, DEADLOCK} state_t;

  state_t              r_state;
  logic [PCNT_W-1:0]   r_pcnt;
  logic                r_block;
  logic                r_sticky;
  logic [N_AXIS-1:0]   r_info;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_count;

  logic [N_PROC-1:0]   w_axis_blk;
  logic [N_PROC-1:0]   w_stop;
  logic                w_cand;
  logic                w_entry;
  logic [IDX_W-1:0]    w_first_idx;

  generate
    for (genvar gi = 0; gi < N_PROC; gi++) begin : g_proc
      assign w_axis_blk[gi] = child_block[gi] &
                              (|(axis_block_sigs & PROC_AXIS_MASK[gi*N_AXIS +: N_AXIS]));
      assign w_stop[gi]     = inst_idle_sigs[gi] | inst_block_sigs[gi] | w_axis_blk[gi];
    end
  endgenerate

  assign w_cand  = (|w_axis_blk) & (&w_stop);
  assign w_entry = w_cand &
                   (((r_state == IDLE) && (PERSIST == 1)) ||
                    ((r_state == ARMED) && (r_pcnt == PCNT_W'(PERSIST - 1))));

  // Descending scan so the lowest set index is the one left standing.
  always_comb begin
    w_first_idx = '0;
    for (int a = N_AXIS - 1; a >= 0; a--) begin
      if (axis_block_sigs[a]) w_first_idx = IDX_W'(a);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pcnt  <= '0;
      r_block <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cand) begin
            if (PERSIST == 1) begin
              r_state <= DEADLOCK;
              r_block <= 1'b1;
            end else begin
              r_state <= ARMED;
              r_pcnt  <= PCNT_W'(1);
            end
          end
        end
        ARMED: begin
          if (!w_cand) begin
            r_state <= IDLE;
            r_pcnt  <= '0;
          end else if (r_pcnt == PCNT_W'(PERSIST - 1)) begin
            r_state <= DEADLOCK;
            r_pcnt  <= '0;
            r_block <= 1'b1;
          end else begin
            r_pcnt <= r_pcnt + PCNT_W'(1);
          end
        end
        DEADLOCK: begin
          if (!w_cand) begin
            r_state <= IDLE;
            r_block <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_pcnt  <= '0;
          r_block <= 1'b0;
        end
      endcase
    end
  end

  // An entry beats a simultaneous clear: the count restarts at one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sticky <= 1'b0;
      r_info   <= '0;
      r_idx    <= '0;
      r_count  <= '0;
    end else if (w_entry) begin
      r_sticky <= 1'b1;
      r_info   <= axis_block_sigs;
      r_idx    <= w_first_idx;
      if (clear)
        r_count <= CNT_W'(1);
      else if (!(&r_count))
        r_count <= r_count + CNT_W'(1);
    end else if (clear) begin
      r_sticky <= 1'b0;
      r_info   <= '0;
      r_idx    <= '0;
      r_count  <= '0;
    end
  end

  assign block           = r_block;
  assign block_sticky    = r_sticky;
  assign axis_block_info = r_info;
  assign first_axis_idx  = r_idx;
  assign event_count     = r_count;

endmodule

// File: tb/tb_hls_deadlock_monitor_gen.sv
// Scoreboard bench: two monitor instances (PERSIST=1/CNT_W=16 and PERSIST=4/CNT_W=2)
// share stimulus; a run-length reference model predicts every post-edge output.
module tb_hls_deadlock_monitor_gen;
  localparam int NP = 3;
  localparam int NA = 2;
  localparam logic [5:0] MASK = 6'b001100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NA-1:0] axis = '0;
  logic [NP-1:0] idle = '0, iblk = '0, child = '0;
  logic clr = 1'b0;

  logic        blk0, st0, idx0;
  logic [1:0]  info0;
  logic [15:0] cnt0;
  logic        blk1, st1, idx1;
  logic [1:0]  info1;
  logic [1:0]  cnt1;

  always #5 clk = ~clk;

  hls_deadlock_monitor_gen u_dut0 (
    .clock(clk), .reset(rst_n), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(iblk), .child_block(child), .clear(clr),
    .block(blk0), .block_sticky(st0), .axis_block_info(info0),
    .first_axis_idx(idx0), .event_count(cnt0));

  hls_deadlock_monitor_gen #(.PERSIST(4), .CNT_W(2)) u_dut1 (
    .clock(clk), .reset(rst_n), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(iblk), .child_block(child), .clear(clr),
    .block(blk1), .block_sticky(st1), .axis_block_info(info1),
    .first_axis_idx(idx1), .event_count(cnt1));

  typedef struct { int blk; int st; int info; int idx; int cnt; } obs_t;
  typedef struct { obs_t d0; obs_t d1; } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: consecutive-cand run length per instance.
  int m_run[2], m_st[2], m_info[2], m_idx[2], m_cnt[2];

  function automatic int persist_of(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int cmax_of(int i);
    return (i == 0) ? 65535 : 3;
  endfunction

  function automatic int ref_cand();
    logic [5:0] mk = MASK;
    int any_ab = 0;
    int all_stop = 1;
    for (int p = 0; p < NP; p++) begin
      int ab = (child[p] && ((axis & mk[p*NA +: NA]) != 0)) ? 1 : 0;
      int stp = (idle[p] || iblk[p] || ab != 0) ? 1 : 0;
      if (ab != 0) any_ab = 1;
      if (stp == 0) all_stop = 0;
    end
    return any_ab & all_stop;
  endfunction

  function automatic int lowest_bit(int v);
    for (int a = 0; a < NA; a++) if (((v >> a) & 1) != 0) return a;
    return 0;
  endfunction

  task automatic model_update();
    int c;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i] = 0; m_st[i] = 0; m_info[i] = 0; m_idx[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      c = ref_cand();
      for (int i = 0; i < 2; i++) begin
        if (c != 0) m_run[i] = (m_run[i] < 1000) ? m_run[i] + 1 : m_run[i];
        else        m_run[i] = 0;
        if (c != 0 && m_run[i] == persist_of(i)) begin
          m_st[i]   = 1;
          m_info[i] = int'(axis);
          m_idx[i]  = lowest_bit(int'(axis));
          if (clr)                        m_cnt[i] = 1;
          else if (m_cnt[i] < cmax_of(i)) m_cnt[i] = m_cnt[i] + 1;
        end else if (clr) begin
          m_st[i] = 0; m_info[i] = 0; m_idx[i] = 0; m_cnt[i] = 0;
        end
      end
    end
  endtask

  function automatic obs_t snap(int i);
    obs_t o;
    o.blk  = (m_run[i] >= persist_of(i)) ? 1 : 0;
    o.st   = m_st[i];
    o.info = m_info[i];
    o.idx  = m_idx[i];
    o.cnt  = m_cnt[i];
    return o;
  endfunction

  // One clock edge: optionally assert reset right after it, then predict and queue.
  task automatic tick(input logic assert_rst);
    exp_t e;
    @(posedge clk);
    #1;
    if (assert_rst) rst_n = 1'b0;
    model_update();
    e.d0 = snap(0);
    e.d1 = snap(1);
    q.push_back(e);
  endtask

  task automatic drive(input logic [2:0] i_idle, input logic [2:0] i_blk,
                       input logic [2:0] i_child, input logic [1:0] i_axis,
                       input logic i_clr);
    idle = i_idle; iblk = i_blk; child = i_child; axis = i_axis; clr = i_clr;
    tick(1'b0);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    int txn = 0;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("block[P1]",  int'(blk0),  e.d0.blk);
        chk("sticky[P1]", int'(st0),   e.d0.st);
        chk("info[P1]",   int'(info0), e.d0.info);
        chk("idx[P1]",    int'(idx0),  e.d0.idx);
        chk("count[P1]",  int'(cnt0),  e.d0.cnt);
        chk("block[P4]",  int'(blk1),  e.d1.blk);
        chk("sticky[P4]", int'(st1),   e.d1.st);
        chk("info[P4]",   int'(info1), e.d1.info);
        chk("idx[P4]",    int'(idx1),  e.d1.idx);
        chk("count[P4]",  int'(cnt1),  e.d1.cnt);
        $display("txn %0d rst_n=%0d blk=%0d/%0d sticky=%0d/%0d cnt=%0d/%0d",
                 txn, rst_n, blk0, blk1, st0, st1, cnt0, cnt1);
        txn++;
      end
    end
  end

  localparam logic [2:0] C_IDLE = 3'b101;

  initial begin : stimulus
    int waited;
    tick(1'b0);
    tick(1'b0);
    rst_n = 1'b1;

    // Basic entry, then persistence: 3 cand, 1 gap, 4+1 cand.
    drive(C_IDLE, 3'b000, 3'b111, 2'b10, 1'b0);
    drive(C_IDLE, 3'b000, 3'b111, 2'b10, 1'b0);
    drive(C_IDLE, 3'b000, 3'b111, 2'b10, 1'b0);
    drive(3'b000, 3'b000, 3'b111, 2'b10, 1'b0);
    repeat (5) drive(C_IDLE, 3'b000, 3'b111, 2'b10, 1'b0);

    // Drop, then clear.
    drive(3'b000, 3'b000, 3'b111, 2'b10, 1'b0);
    drive(3'b000, 3'b000, 3'b111, 2'b10, 1'b1);
    drive(3'b000, 3'b000, 3'b111, 2'b10, 1'b0);

    // Clear coincident with a fresh entry.
    drive(C_IDLE, 3'b000, 3'b111, 2'b11, 1'b1);
    drive(C_IDLE, 3'b000, 3'b111, 2'b11, 1'b0);
    drive(3'b000, 3'b000, 3'b111, 2'b00, 1'b0);

    // Five separate entries: the narrow counter saturates.
    repeat (5) begin
      repeat (4) drive(C_IDLE, 3'b000, 3'b111, 2'b01, 1'b0);
      drive(3'b000, 3'b010, 3'b111, 2'b01, 1'b0);
    end

    // Reset while in deadlock, then release with cand held.
    repeat (4) drive(C_IDLE, 3'b000, 3'b111, 2'b10, 1'b0);
    tick(1'b1);
    tick(1'b0);
    rst_n = 1'b1;
    repeat (5) drive(C_IDLE, 3'b000, 3'b111, 2'b10, 1'b0);

    // Randomised traffic biased toward candidate deadlock.
    repeat (500) begin
      logic [2:0] r_idle, r_blk, r_child;
      r_idle  = 3'($urandom_range(0, 7)) | (($urandom_range(0, 3) != 0) ? 3'b101 : 3'b000);
      r_blk   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      r_child = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
      drive(r_idle, r_blk, r_child, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end

    drive(3'b000, 3'b000, 3'b000, 2'b00, 1'b0);
    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
